// File: rtl/clock_mode_ctrl_pkg.sv
// Shared types and constants for the alarm clock mode controller:
// mode encodings, default moduli and counter field widths.
package clock_mode_ctrl_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HR_W   = 5;
    localparam int MODE_W = 3;

    localparam int SEC_MOD_DEF   = 60;
    localparam int MIN_MOD_DEF   = 60;
    localparam int HR_MOD_DEF    = 24;
    localparam int RING_SECS_DEF = 60;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN     = 3'd0,
        MODE_SET_HR  = 3'd1,
        MODE_SET_MIN = 3'd2,
        MODE_ALM_HR  = 3'd3,
        MODE_ALM_MIN = 3'd4
    } mode_e;

    // Any unexpected encoding falls back to RUN so the FSM always recovers.
    function automatic mode_e nextMode(input mode_e cur);
        case (cur)
            MODE_RUN:     return MODE_SET_HR;
            MODE_SET_HR:  return MODE_SET_MIN;
            MODE_SET_MIN: return MODE_ALM_HR;
            MODE_ALM_HR:  return MODE_ALM_MIN;
            default:      return MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// Bundle between button/counter side and the mode controller. The slave
// modport is the controller view; master is whoever drives buttons and counters.
interface clock_mode_ctrl_if;
    import clock_mode_ctrl_pkg::*;

    logic              tick_1hz;
    logic              btn_mode;
    logic              btn_inc;
    logic              btn_stop;
    logic              alarm_en;
    logic [SEC_W-1:0]  sec_cnt;
    logic [MIN_W-1:0]  min_cnt;
    logic [HR_W-1:0]   hr_cnt;
    logic [MIN_W-1:0]  alm_min;
    logic [HR_W-1:0]   alm_hr;

    logic              sec_en;
    logic              min_en;
    logic              hr_en;
    logic              alm_min_en;
    logic              alm_hr_en;
    logic [MODE_W-1:0] mode;
    logic              ringing;
    logic              ring_led;

    modport master (
        output tick_1hz, btn_mode, btn_inc, btn_stop, alarm_en,
        output sec_cnt, min_cnt, hr_cnt, alm_min, alm_hr,
        input  sec_en, min_en, hr_en, alm_min_en, alm_hr_en,
        input  mode, ringing, ring_led
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, btn_stop, alarm_en,
        input  sec_cnt, min_cnt, hr_cnt, alm_min, alm_hr,
        output sec_en, min_en, hr_en, alm_min_en, alm_hr_en,
        output mode, ringing, ring_led
    );

endinterface

// File: rtl/alarm_ring_timer.sv
// Alarm ringing state: rising-edge detect on the match condition, ringing flag,
// per-tick ring timer with auto-stop, and the blinking ring LED.
module alarm_ring_timer #(
    parameter int RING_SECS = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic match_i,
    input  logic stop_i,
    input  logic alarmEn_i,
    input  logic modeBtn_i,
    output logic ringing_o,
    output logic ringLed_o
);

    localparam int TIMER_W = $clog2(RING_SECS + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RING_SECS - 1);

    logic               match_q;
    logic               ringing_q, ringing_d;
    logic               ringLed_q, ringLed_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               rise;
    logic               expire;
    logic               clearReq;

    // Clear has priority over a new trigger, so a stop on the matching cycle wins.
    always_comb begin
        rise      = match_i & ~match_q;
        expire    = ringing_q & tick_i & (timer_q == TIMER_LAST);
        clearReq  = stop_i | ~alarmEn_i | modeBtn_i | expire;
        ringing_d = ringing_q;
        ringLed_d = ringLed_q;
        timer_d   = timer_q;
        if (clearReq) begin
            ringing_d = 1'b0;
            ringLed_d = 1'b0;
            timer_d   = '0;
        end else if (ringing_q) begin
            if (tick_i) begin
                timer_d   = timer_q + TIMER_W'(1);
                ringLed_d = ~ringLed_q;
            end
        end else if (rise) begin
            ringing_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_q   <= 1'b0;
            ringing_q <= 1'b0;
            ringLed_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            match_q   <= match_i;
            ringing_q <= ringing_d;
            ringLed_q <= ringLed_d;
            timer_q   <= timer_d;
        end
    end

    assign ringing_o = ringing_q;
    assign ringLed_o = ringLed_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Alarm clock central controller: user mode FSM, registered enable pulses for the
// time and alarm counter bank, and the alarm match feeding the ring timer.
module clock_mode_ctrl
    import clock_mode_ctrl_pkg::*;
#(
    parameter int SEC_MOD   = SEC_MOD_DEF,
    parameter int MIN_MOD   = MIN_MOD_DEF,
    parameter int RING_SECS = RING_SECS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    clock_mode_ctrl_if.slave bus
);

    mode_e mode_q, mode_d;
    logic  secEn_q, secEn_d;
    logic  minEn_q, minEn_d;
    logic  hrEn_q, hrEn_d;
    logic  almMinEn_q, almMinEn_d;
    logic  almHrEn_q, almHrEn_d;

    logic  secLast;
    logic  minLast;
    logic  incReq;
    logic  match;
    logic  ringing;
    logic  ringLed;

    assign secLast = (bus.sec_cnt == SEC_W'(SEC_MOD - 1));
    assign minLast = (bus.min_cnt == MIN_W'(MIN_MOD - 1));
    // A mode press in the same cycle swallows the increment.
    assign incReq  = bus.btn_inc & ~bus.btn_mode;

    always_comb begin
        mode_d     = mode_q;
        secEn_d    = 1'b0;
        minEn_d    = 1'b0;
        hrEn_d     = 1'b0;
        almMinEn_d = 1'b0;
        almHrEn_d  = 1'b0;
        if (bus.btn_mode) begin
            mode_d = nextMode(mode_q);
        end
        case (mode_q)
            MODE_RUN, MODE_ALM_HR, MODE_ALM_MIN: begin
                secEn_d = bus.tick_1hz;
                minEn_d = bus.tick_1hz & secLast;
                hrEn_d  = bus.tick_1hz & secLast & minLast;
            end
            MODE_SET_HR:  hrEn_d  = incReq;
            MODE_SET_MIN: minEn_d = incReq;
            default: ;
        endcase
        almHrEn_d  = (mode_q == MODE_ALM_HR)  & incReq;
        almMinEn_d = (mode_q == MODE_ALM_MIN) & incReq;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q     <= MODE_RUN;
            secEn_q    <= 1'b0;
            minEn_q    <= 1'b0;
            hrEn_q     <= 1'b0;
            almMinEn_q <= 1'b0;
            almHrEn_q  <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            secEn_q    <= secEn_d;
            minEn_q    <= minEn_d;
            hrEn_q     <= hrEn_d;
            almMinEn_q <= almMinEn_d;
            almHrEn_q  <= almHrEn_d;
        end
    end

    // Only the top of a matching minute in RUN counts as an alarm hit.
    assign match = bus.alarm_en
                 & (mode_q == MODE_RUN)
                 & (bus.sec_cnt == '0)
                 & (bus.min_cnt == bus.alm_min)
                 & (bus.hr_cnt == bus.alm_hr);

    alarm_ring_timer #(
        .RING_SECS (RING_SECS)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .tick_i    (bus.tick_1hz),
        .match_i   (match),
        .stop_i    (bus.btn_stop),
        .alarmEn_i (bus.alarm_en),
        .modeBtn_i (bus.btn_mode),
        .ringing_o (ringing),
        .ringLed_o (ringLed)
    );

    assign bus.sec_en     = secEn_q;
    assign bus.min_en     = minEn_q;
    assign bus.hr_en      = hrEn_q;
    assign bus.alm_min_en = almMinEn_q;
    assign bus.alm_hr_en  = almHrEn_q;
    assign bus.mode       = mode_q;
    assign bus.ringing    = ringing;
    assign bus.ring_led   = ringLed;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: directed vectors push hand-computed
// post-edge outputs; a monitor pops and compares them on each falling edge.
module tb_clock_mode_ctrl;

    logic clk;
    logic reset;

    int compared;
    int mismatched;

    logic       alarmEn;
    logic [5:0] almMin;
    logic [4:0] almHr;

    typedef struct {
        logic [9:0] exp;
        string      name;
    } expItem_t;

    expItem_t expQ[$];

    clock_mode_ctrl_if bus ();

    clock_mode_ctrl #(
        .SEC_MOD   (60),
        .MIN_MOD   (60),
        .RING_SECS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {sec,min,hr,almMin,almHr enables, mode, ringing, ringLed}.
    function automatic logic [9:0] E(input logic [4:0] en, input logic [2:0] md,
                                     input logic r, input logic l);
        return {en, md, r, l};
    endfunction

    task automatic checkOutput(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {bus.sec_en, bus.min_en, bus.hr_en, bus.alm_min_en, bus.alm_hr_en,
               bus.mode, bus.ringing, bus.ring_led};
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b (en5|mode3|ring|led)", name, act, exp);
        end
    endtask

    task automatic driveInputs(input logic t, input logic bm, input logic bi, input logic bs,
                               input logic [5:0] s, input logic [5:0] m, input logic [4:0] h);
        bus.tick_1hz = t;
        bus.btn_mode = bm;
        bus.btn_inc  = bi;
        bus.btn_stop = bs;
        bus.sec_cnt  = s;
        bus.min_cnt  = m;
        bus.hr_cnt   = h;
        bus.alarm_en = alarmEn;
        bus.alm_min  = almMin;
        bus.alm_hr   = almHr;
    endtask

    task automatic applyStimulus(input logic t, input logic bm, input logic bi, input logic bs,
                                 input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                                 input logic [9:0] exp, input string name);
        expItem_t it;
        @(negedge clk);
        #1;
        driveInputs(t, bm, bi, bs, s, m, h);
        it.exp  = exp;
        it.name = name;
        expQ.push_back(it);
    endtask

    task automatic resetPulse(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h);
        expItem_t it;
        @(negedge clk);
        #1;
        driveInputs(1'b0, 1'b0, 1'b0, 1'b0, s, m, h);
        reset = 1'b1;
        #1;
        checkOutput("resetImmediate", E(5'b00000, 3'd0, 1'b0, 1'b0));
        it.exp  = E(5'b00000, 3'd0, 1'b0, 1'b0);
        it.name = "resetHeld";
        expQ.push_back(it);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        expItem_t it;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                it = expQ.pop_front();
                checkOutput(it.name, it.exp);
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        alarmEn    = 1'b0;
        almMin     = 6'd30;
        almHr      = 5'd7;
        reset      = 1'b1;
        driveInputs(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 5'd0);
        @(negedge clk);
        checkOutput("resetState", E(5'b00000, 3'd0, 1'b0, 1'b0));
        #1;
        reset = 1'b0;

        // RUN carries
        applyStimulus(1, 0, 0, 0, 59, 59, 23, E(5'b11100, 0, 0, 0), "wrapAll");
        applyStimulus(1, 0, 0, 0, 58, 34, 12, E(5'b10000, 0, 0, 0), "secOnly");
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, 0, 0, 58, 34, 12, E(5'b00000, 0, 0, 0), "noTickIdle");
        applyStimulus(1, 0, 0, 0, 59, 34, 12, E(5'b11000, 0, 0, 0), "minCarry");
        applyStimulus(1, 0, 0, 0, 58, 59, 12, E(5'b10000, 0, 0, 0), "min59NoCarry");
        applyStimulus(0, 0, 1, 0, 58, 34, 12, E(5'b00000, 0, 0, 0), "incIgnoredRun");

        // SET_HR: time frozen, inc drives hr
        applyStimulus(0, 1, 0, 0, 58, 34, 12, E(5'b00000, 1, 0, 0), "toSetHr");
        applyStimulus(1, 0, 0, 0, 59, 59, 23, E(5'b00000, 1, 0, 0), "setHrTick1");
        applyStimulus(0, 0, 1, 0, 59, 59, 23, E(5'b00100, 1, 0, 0), "setHrInc1");
        applyStimulus(1, 0, 0, 0, 59, 59, 23, E(5'b00000, 1, 0, 0), "setHrTick2");
        applyStimulus(0, 0, 1, 0, 59, 59, 23, E(5'b00100, 1, 0, 0), "setHrInc2");
        applyStimulus(1, 0, 0, 0, 59, 59, 23, E(5'b00000, 1, 0, 0), "setHrTick3");

        // SET_MIN: inc drives min, no carry, mode+inc drops inc
        applyStimulus(0, 1, 0, 0, 59, 59, 23, E(5'b00000, 2, 0, 0), "toSetMin");
        applyStimulus(0, 0, 1, 0, 59, 59, 23, E(5'b01000, 2, 0, 0), "setMinInc");
        applyStimulus(1, 0, 1, 0, 59, 59, 23, E(5'b01000, 2, 0, 0), "setMinNoCarry");
        applyStimulus(0, 1, 1, 0, 59, 59, 23, E(5'b00000, 3, 0, 0), "modeIncSame");

        // Alarm setting modes: time keeps running
        applyStimulus(0, 0, 1, 0, 59, 34, 12, E(5'b00001, 3, 0, 0), "almHrInc");
        applyStimulus(1, 0, 0, 0, 59, 34, 12, E(5'b11000, 3, 0, 0), "almHrTimeRuns");
        applyStimulus(0, 1, 0, 0, 59, 34, 12, E(5'b00000, 4, 0, 0), "toAlmMin");
        applyStimulus(1, 0, 1, 0, 10, 34, 12, E(5'b10010, 4, 0, 0), "almMinIncTick");
        applyStimulus(0, 1, 0, 0, 10, 34, 12, E(5'b00000, 0, 0, 0), "backToRun");

        // Alarm 07:30 trigger and stop
        alarmEn = 1'b1;
        applyStimulus(1, 0, 0, 0, 59, 29, 7, E(5'b11000, 0, 0, 0), "preAlarm");
        applyStimulus(0, 0, 0, 0, 0, 30, 7, E(5'b00000, 0, 1, 0), "ringStart");
        applyStimulus(0, 0, 0, 0, 0, 30, 7, E(5'b00000, 0, 1, 0), "ringHold");
        applyStimulus(1, 0, 0, 0, 0, 30, 7, E(5'b10000, 0, 1, 1), "ringLedOn");
        applyStimulus(0, 0, 0, 1, 0, 30, 7, E(5'b00000, 0, 0, 0), "stopClears");
        applyStimulus(0, 0, 0, 0, 0, 30, 7, E(5'b00000, 0, 0, 0), "noRetrigger");
        applyStimulus(1, 0, 0, 0, 0, 30, 7, E(5'b10000, 0, 0, 0), "noRetriggerTick");
        applyStimulus(0, 0, 0, 0, 1, 30, 7, E(5'b00000, 0, 0, 0), "restOfMinute");

        // Auto-stop after RING_SECS=3 ticks
        almMin = 6'd31;
        applyStimulus(0, 0, 0, 0, 0, 31, 7, E(5'b00000, 0, 1, 0), "ring2Start");
        applyStimulus(1, 0, 0, 0, 0, 31, 7, E(5'b10000, 0, 1, 1), "ring2Tick1");
        applyStimulus(0, 0, 0, 0, 1, 31, 7, E(5'b00000, 0, 1, 1), "ring2Idle");
        applyStimulus(1, 0, 0, 0, 1, 31, 7, E(5'b10000, 0, 1, 0), "ring2Tick2");
        applyStimulus(1, 0, 0, 0, 2, 31, 7, E(5'b10000, 0, 0, 0), "autoStop");
        applyStimulus(1, 0, 0, 0, 3, 31, 7, E(5'b10000, 0, 0, 0), "afterAutoStop");
        applyStimulus(0, 0, 0, 1, 4, 31, 7, E(5'b00000, 0, 0, 0), "stopNotRinging");

        // alarm_en low and btn_mode both silence
        almMin = 6'd32;
        applyStimulus(0, 0, 0, 0, 0, 32, 7, E(5'b00000, 0, 1, 0), "ring3Start");
        alarmEn = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 32, 7, E(5'b00000, 0, 0, 0), "alarmEnLow");
        alarmEn = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 32, 7, E(5'b00000, 0, 0, 0), "alarmEnBack");
        almMin = 6'd33;
        applyStimulus(0, 0, 0, 0, 0, 33, 7, E(5'b00000, 0, 1, 0), "ring4Start");
        applyStimulus(0, 1, 0, 0, 0, 33, 7, E(5'b00000, 1, 0, 0), "modeClears");
        applyStimulus(0, 1, 0, 0, 1, 33, 7, E(5'b00000, 2, 0, 0), "cycleMode2");
        applyStimulus(0, 1, 0, 0, 1, 33, 7, E(5'b00000, 3, 0, 0), "cycleMode3");
        applyStimulus(0, 1, 0, 0, 1, 33, 7, E(5'b00000, 4, 0, 0), "cycleMode4");
        applyStimulus(0, 1, 0, 0, 1, 33, 7, E(5'b00000, 0, 0, 0), "cycleMode0");

        // Reset while ringing with LED lit
        almMin = 6'd34;
        applyStimulus(0, 0, 0, 0, 0, 34, 7, E(5'b00000, 0, 1, 0), "ring5Start");
        applyStimulus(1, 0, 0, 0, 0, 34, 7, E(5'b10000, 0, 1, 1), "ring5LedOn");
        resetPulse(6'd5, 6'd34, 5'd7);
        applyStimulus(0, 0, 0, 0, 5, 34, 7, E(5'b00000, 0, 0, 0), "afterReset");

        for (int i = 0; i < 20 && expQ.size() > 0; i++)
            @(negedge clk);
        #1;
        if (expQ.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
